// File: rtl/jtkiwi_pkg.sv
// Shared types and constants for the Kiwi object line-buffer path.
package jtkiwi_pkg;

    localparam int unsigned OBJ_W   = 16;
    localparam int unsigned LBUF_AW = 9;
    localparam int unsigned PXL_W   = 9;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDraw
    } objdraw_st_t;

    // Picks pixel idx from a 32-bit row word; hflip mirrors it to nibble 7-idx.
    function automatic logic [3:0] pick_pen(input logic [31:0] data, input logic [2:0] idx,
                                            input logic flip);
        logic [2:0] n;
        n = flip ? ~idx : idx;
        return data[{n, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/jtkiwi_objbuf.sv
// Two-bank 512x9 object line buffer: port A draws into `bank`, port B reads
// the other bank and erases each location on the clk after it is read.
module jtkiwi_objbuf
    import jtkiwi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               bank,
    input  logic               wr_en,
    input  logic [LBUF_AW-1:0] wr_addr,
    input  logic [PXL_W-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [LBUF_AW-1:0] rd_addr,
    output logic [PXL_W-1:0]   rd_data
);

    localparam int unsigned Depth = 2 * (1 << LBUF_AW);

    logic [PXL_W-1:0] mem [Depth];
    logic             erase;
    logic [LBUF_AW:0] erase_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data    <= '0;
            erase      <= 1'b0;
            erase_addr <= '0;
        end else begin
            erase <= rd_en;
            if (rd_en) begin
                rd_data    <= mem[{~bank, rd_addr}];
                erase_addr <= {~bank, rd_addr};
            end
        end
    end

    // A draw write lands after the erase so it wins if both hit one location.
    always_ff @(posedge clk) begin
        if (erase) mem[erase_addr] <= '0;
        if (wr_en) mem[{bank, wr_addr}] <= wr_data;
    end

endmodule

// File: rtl/jtkiwi_objdraw.sv
// Object line-buffer drawer: fetches 16-pixel 4bpp object rows and draws them.
// Define JTKIWI_OBJ_OVF_EN to flag lines whose drawing was cut short by hs.
module jtkiwi_objdraw
    import jtkiwi_pkg::*;
#(
    parameter int unsigned AW = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pxl_cen,
    input  logic               hs,
    input  logic [8:0]         hdump,
    input  logic               draw,
    input  logic [12:0]        code,
    input  logic [3:0]         row,
    input  logic [8:0]         xpos,
    input  logic [4:0]         pal,
    input  logic               hflip,
    input  logic               vflip,
    output logic               busy,
    output logic [AW-1:0]      rom_addr,
    output logic               rom_cs,
    input  logic               rom_ok,
    input  logic [31:0]        rom_data,
    output logic [PXL_W-1:0]   pxl,
    output logic               ovf
);

    objdraw_st_t st;

    logic               hs_l;
    logic               bank;
    logic               first;
    logic               half;
    logic               k;
    logic [2:0]         cnt;
    logic [12:0]        code_q;
    logic [3:0]         row_q;
    logic [8:0]         xpos_q;
    logic [4:0]         pal_q;
    logic               hflip_q;
    logic [31:0]        data_q;

    logic               swap;
    logic [3:0]         pen;
    logic [LBUF_AW-1:0] wr_x;
    logic               wr_en;

    assign swap  = hs & ~hs_l;
    assign pen   = pick_pen(data_q, cnt, hflip_q);
    assign wr_x  = xpos_q + {5'd0, k, cnt};
    assign wr_en = (st == StDraw) && (pen != 4'd0) && !swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= StIdle;
            busy     <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            hs_l     <= 1'b0;
            bank     <= 1'b0;
            first    <= 1'b0;
            half     <= 1'b0;
            k        <= 1'b0;
            cnt      <= 3'd0;
            code_q   <= '0;
            row_q    <= '0;
            xpos_q   <= '0;
            pal_q    <= '0;
            hflip_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            hs_l <= hs;
            if (swap) begin
                // Line boundary: whatever is unfinished is dropped.
                bank   <= ~bank;
                st     <= StIdle;
                busy   <= 1'b0;
                rom_cs <= 1'b0;
            end else begin
                case (st)
                    StIdle: begin
                        if (draw) begin
                            code_q   <= code;
                            row_q    <= row ^ {4{vflip}};
                            xpos_q   <= xpos;
                            pal_q    <= pal;
                            hflip_q  <= hflip;
                            half     <= hflip;
                            k        <= 1'b0;
                            cnt      <= 3'd0;
                            first    <= 1'b1;
                            busy     <= 1'b1;
                            rom_cs   <= 1'b1;
                            rom_addr <= AW'({code, row ^ {4{vflip}}, hflip});
                            st       <= StFetch;
                        end
                    end
                    StFetch: begin
                        first <= 1'b0;
                        // rom_ok in the first cycle may belong to the previous address.
                        if (!first && rom_ok) begin
                            data_q <= rom_data;
                            rom_cs <= 1'b0;
                            cnt    <= 3'd0;
                            st     <= StDraw;
                        end
                    end
                    StDraw: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'(OBJ_W / 2 - 1)) begin
                            if (!k) begin
                                k        <= 1'b1;
                                half     <= ~half;
                                first    <= 1'b1;
                                rom_cs   <= 1'b1;
                                rom_addr <= AW'({code_q, row_q, ~half});
                                st       <= StFetch;
                            end else begin
                                busy <= 1'b0;
                                st   <= StIdle;
                            end
                        end
                    end
                    default: st <= StIdle;
                endcase
            end
        end
    end

`ifdef JTKIWI_OBJ_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (swap) begin
            ovf <= busy;
        end
    end
`else
    assign ovf = 1'b0;
`endif

    jtkiwi_objbuf u_objbuf (
        .clk     (clk),
        .rst     (rst),
        .bank    (bank),
        .wr_en   (wr_en),
        .wr_addr (wr_x),
        .wr_data ({pal_q, pen}),
        .rd_en   (pxl_cen),
        .rd_addr (hdump),
        .rd_data (pxl)
    );

endmodule

// File: doc/jtkiwi_objdraw.md
# jtkiwi_objdraw

Object line-buffer drawer for the Kiwi video path, sitting between the object-table scanner and the colour mixer inside the video block. For each accepted draw request it fetches one 16-pixel row of a 4bpp object from SDRAM over the obj ROM port and writes the opaque pixels into a double-buffered 512-entry line buffer. It reads the other bank out in step with `hdump`, producing a 9-bit palette-indexed object pixel per dot and erasing each location after it is read.

## Interface
Parameters:
- `AW`, 18: ROM word-address width; address layout is {code[12:0], row[3:0], half}.

Ports:
- `clk`  in  1  system clock, 24 MHz; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `pxl_cen`  in  1  pixel clock enable.
- `hs`  in  1  horizontal sync; its rising edge swaps the line-buffer banks.
- `hdump`  in  9  current horizontal dot, used as the readout address.
- `draw`  in  1  draw request; accepted only while `busy`=0.
- `code`  in  13  object tile code.
- `row`  in  4  row within the object, before vflip.
- `xpos`  in  9  left x coordinate.
- `pal`  in  5  palette bank.
- `hflip`, `vflip`  in  1 each  flip controls.
- `busy`  out  1  high from request acceptance until the object is finished or aborted.
- `rom_addr`  out  AW  SDRAM word address.
- `rom_cs`  out  1  SDRAM request.
- `rom_ok`  in  1  SDRAM data valid.
- `rom_data`  in  32  eight 4bpp pixels; nibble i = bits [4i+3:4i].
- `pxl`  out  9  {pal, pen}; pen 0 means transparent.
- `ovf`  out  1  line overflow flag; see Configuration.

## Operation
- FSM states: IDLE, FETCH, DRAW.
- IDLE to FETCH: taken on `draw`. All request fields are latched, `busy` goes high, and `half` is set to hflip.
- FETCH: drives `rom_cs`=1 and `rom_addr`={code, row^{4{vflip}}, half}.
  - `rom_ok` is ignored in the first FETCH cycle, because it may be stale from the previous address.
  - From the second cycle on, `rom_ok`=1 latches `rom_data`, drops `rom_cs` and moves to DRAW.
- DRAW: 8 cycles, one pixel per clk.
  - Pixel i is taken from nibble i, or from nibble 7-i when hflip=1.
  - It is written to x = xpos + 8·k + i, modulo 512, where k counts halves drawn so far (0 or 1).
  - Pen 0 is not written.
  - Later objects overwrite earlier ones; there is no priority compare.
- After the first half, `half` toggles and the FSM returns to FETCH. After the second half it goes to IDLE and `busy` drops.
- Readout runs on the bank not being drawn.
  - On `pxl_cen` the buffer is read at `hdump`.
  - One clk later the data is registered into `pxl` and the same location is written with 0.
- Bank swap happens on the clk after an `hs` rising edge.
  - An object in progress at the swap is aborted: FSM goes to IDLE, `busy` goes to 0, `rom_cs` goes to 0.
  - A `draw` arriving in the swap cycle is ignored.
- Reset values: `busy`=0, `rom_cs`=0, `rom_addr`=0, `pxl`=0, `ovf`=0, FSM=IDLE, bank select=0.
- Line-buffer contents are not cleared by reset. The first two lines after reset are undefined.

## Timing
- Request to `rom_cs`: 1 clk.
- Per half: at least 2 FETCH clks + 8 DRAW clks.
- Whole object: at least 20 clks.
- `busy` falls the clk after the last DRAW write.
- Readout latency: `pxl` is valid 1 clk after the `pxl_cen` at which `hdump` was sampled. It is held until the next readout.
- `draw` and the `hs` edge in the same clk: the swap wins.

## Configuration
- `JTKIWI_OBJ_OVF_EN` defined:
  - An abort at bank swap sets `ovf`=1.
  - `ovf` stays high until the next bank swap that aborts nothing; it then clears.
- `JTKIWI_OBJ_OVF_EN` undefined:
  - `ovf` is tied to 0.
  - Abort behaviour is unchanged.

## Structure
- Shared package `jtkiwi_pkg`, holding:
  - FSM state encoding `objdraw_st_t`;
  - the constants `OBJ_W`=16, `LBUF_AW`=9 and `PXL_W`=9.
- One sub-module, `jtkiwi_objbuf`: a two-bank 512×9 dual-port line buffer.
  - Port A: draw writes.
  - Port B: readout plus erase.
  - Bank select is an input.
- The FSM, address generation and flip logic stay in `jtkiwi_objdraw`.

## Test plan
- Basic draw:
  - Stimulus: code=0x0123, row=5, xpos=40, pal=3, no flips, ROM returns 0x87654321 then 0x0FEDCBA9.
  - Expected: `rom_addr` = 0x0123·32 + 5·2 + {0, 1}. After the swap, `pxl` at hdump 40..55 is {3, 1..8, 9..F, 0}, and x=55 reads 0 (transparent).
- Flips:
  - Stimulus: the same data with hflip=1 and vflip=1.
  - Expected: the first fetch uses row 10, half 1. Pixel x=40 gets pen 0 (top nibble of 0x0FEDCBA9, so transparent), x=41 gets 0xF, and so on.
- Wrap:
  - Stimulus: xpos=508, row data 0x11111111 for both halves.
  - Expected: pens written at x=508..511 and x=0..11. No other location is touched.
- Erase:
  - Stimulus: read a drawn line, swap twice with no draws.
  - Expected: all 512 locations read 0.
- Abort and overflow:
  - Stimulus: hold `rom_ok`=0 and raise `hs`.
  - Expected: `busy`, `rom_cs` → 0 the next clk. With `JTKIWI_OBJ_OVF_EN`, `ovf`=1 for one line, then 0.
- Reset mid-object:
  - Stimulus: assert `rst` during DRAW.
  - Expected: the next clk has `busy`=0, `rom_cs`=0, `pxl`=0, and the next `draw` is accepted normally.
